platform_mem_stream_reader: RTL and testbench

PLATFORM_MEM_STREAM_READER -- requirements
Module: platform_mem_stream_reader

---
 rtl/platform_mem_stream_reader_if.sv | 45 ++++
 rtl/platform_mem_stream_reader.sv | 130 +++++++++++++
 tb/tb_platform_mem_stream_reader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/platform_mem_stream_reader_if.sv
// rtl/platform_mem_stream_reader_if.sv - command, RAM read port and stream signals of the reader (optional SOP/EOP under PLATFORM_MEM_STREAM_SOP_EOP_EN)
interface platform_mem_stream_reader_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
);
  logic                start;
  logic [ADDR_W-1:0]   base_addr;
  logic [LEN_W-1:0]    length;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic                mem_clken;
  logic [DATA_W-1:0]   mem_readdata;
  logic [DATA_W-1:0]   src_data;
  logic                src_valid;
  logic                src_ready;
`ifdef PLATFORM_MEM_STREAM_SOP_EOP_EN
  logic                src_startofpacket;
  logic                src_endofpacket;
`endif

  // Reader side: drives status, the RAM read port and the stream
  modport master (
    input  start, base_addr, length, mem_readdata, src_ready,
    output busy, done, mem_address, mem_chipselect, mem_write,
           mem_byteenable, mem_clken, src_data, src_valid
`ifdef PLATFORM_MEM_STREAM_SOP_EOP_EN
    , output src_startofpacket, src_endofpacket
`endif
  );

  // Environment side: issues commands, serves the RAM and sinks the stream
  modport slave (
    output start, base_addr, length, mem_readdata, src_ready,
    input  busy, done, mem_address, mem_chipselect, mem_write,
           mem_byteenable, mem_clken, src_data, src_valid
`ifdef PLATFORM_MEM_STREAM_SOP_EOP_EN
    , input src_startofpacket, src_endofpacket
`endif
  );
endinterface

// File: rtl/platform_mem_stream_reader.sv
// rtl/platform_mem_stream_reader.sv - streams a word range out of 2-cycle-latency on-chip RAM through a credit-limited FIFO (optional SOP/EOP under PLATFORM_MEM_STREAM_SOP_EOP_EN)
module platform_mem_stream_reader #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  platform_mem_stream_reader_if.master  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [LEN_W-1:0]  beats_q;
  logic [CNT_W-1:0]  inflight_q;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [1:0]        pipe_q;
  logic              done_q;
`ifdef PLATFORM_MEM_STREAM_SOP_EOP_EN
  logic [LEN_W-1:0]  len_q;
`endif

  logic              accept_start;
  logic              issue;
  logic              push;
  logic              pop;
  logic              last_pop;
  logic [CNT_W:0]    credit;

  assign accept_start = bus.start && (state_q == S_IDLE);
  assign pop          = (count_q != '0) && bus.src_ready;
  assign last_pop     = pop && (beats_q == LEN_W'(1));
  // Data returns two edges after the issue edge; pipe_q[1] marks that cycle.
  assign push         = pipe_q[1];
  // Every issued read already owns a FIFO slot, so the FIFO can never overflow.
  assign credit       = {1'b0, inflight_q} + {1'b0, count_q} - {{CNT_W{1'b0}}, pop};
  assign issue        = (state_q == S_ISSUE) && (credit < DEPTH_C);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: issue phase ends with the last read, drain ends with the last beat
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start && (bus.length != '0)) state_d = S_ISSUE;
      S_ISSUE: if (issue && (rem_q == LEN_W'(1)))   state_d = S_DRAIN;
      S_DRAIN: if (last_pop)                        state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address/length tracking, in-flight counter, return pipe and FIFO storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pipe_q     <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
`ifdef PLATFORM_MEM_STREAM_SOP_EOP_EN
      len_q      <= '0;
`endif
    end else begin
      if (accept_start) begin
        addr_q  <= bus.base_addr;
        rem_q   <= bus.length;
        beats_q <= bus.length;
`ifdef PLATFORM_MEM_STREAM_SOP_EOP_EN
        len_q   <= bus.length;
`endif
      end else if (issue) begin
        addr_q <= addr_q + 1'b1;
        rem_q  <= rem_q - 1'b1;
      end
      if (pop) beats_q <= beats_q - 1'b1;

      unique case ({issue, push})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
      pipe_q <= {pipe_q[0], issue};

      if (push) begin
        fifo_q[wr_ptr_q] <= bus.mem_readdata;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      done_q <= (accept_start && (bus.length == '0)) || last_pop;
    end
  end

  assign bus.busy           = (state_q != S_IDLE);
  assign bus.done           = done_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_chipselect = issue;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = '1;
  assign bus.mem_clken      = reset_n;
  assign bus.src_valid      = (count_q != '0);
  assign bus.src_data       = fifo_q[rd_ptr_q];
`ifdef PLATFORM_MEM_STREAM_SOP_EOP_EN
  assign bus.src_startofpacket = bus.src_valid && (beats_q == len_q);
  assign bus.src_endofpacket   = bus.src_valid && (beats_q == LEN_W'(1));
`endif
endmodule

// File: tb/tb_platform_mem_stream_reader.sv
// tb/tb_platform_mem_stream_reader.sv - table-driven scoreboard bench for platform_mem_stream_reader
module tb_platform_mem_stream_reader;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;

  platform_mem_stream_reader_if #(.ADDR_W(15), .DATA_W(32), .LEN_W(16)) bus();

  platform_mem_stream_reader #(.ADDR_W(15), .DATA_W(32), .LEN_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: word i holds i, address register then output register (2-cycle latency)
  logic [14:0] ram_addr_q = '0;
  always @(posedge clk) begin
    if (bus.mem_clken) begin
      ram_addr_q       <= bus.mem_address;
      bus.mem_readdata <= {17'b0, ram_addr_q};
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  logic [31:0] exp_q[$];
  logic [14:0] exp_addr;
  int beats, issues, done_cnt, busy_seen, outstanding;
  int first_cyc, last_cyc, done_cyc, start_cyc;
  logic [31:0] first_data, last_data, prev_data, exp_word;
  logic prev_stall = 1'b0;

  // Monitor: sample away from the rising edge and score every beat/issue/done
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall  = 1'b0;
      outstanding = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'b0, bus.src_valid}, 32'd1);
        check("stall_data", bus.src_data, prev_data);
      end
      if (bus.mem_chipselect) begin
        check("issue_addr", {17'b0, bus.mem_address}, {17'b0, exp_addr});
        exp_addr = exp_addr + 15'd1;
        issues++;
      end
      if (bus.src_valid && bus.src_ready) begin
        beats++;
        if (beats == 1) begin
          first_cyc  = cyc;
          first_data = bus.src_data;
        end
        last_cyc  = cyc;
        last_data = bus.src_data;
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL extra_beat actual=%0h expected=none", bus.src_data);
        end else begin
          exp_word = exp_q.pop_front();
          check("beat_data", bus.src_data, exp_word);
        end
`ifdef PLATFORM_MEM_STREAM_SOP_EOP_EN
        check("sop", {31'b0, bus.src_startofpacket}, {31'b0, beats == 1});
        check("eop", {31'b0, bus.src_endofpacket}, {31'b0, exp_q.size() == 0});
`endif
      end
      outstanding = outstanding + int'(bus.mem_chipselect) - int'(bus.src_valid && bus.src_ready);
      if (bus.mem_chipselect) check("outstanding_le4", {31'b0, outstanding <= 4}, 32'd1);
      prev_stall = bus.src_valid && !bus.src_ready;
      prev_data  = bus.src_data;
      if (bus.busy) busy_seen = 1;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", {31'b0, bus.busy}, 32'd0);
      end
    end
  end

  task automatic clear_score(input logic [14:0] base);
    beats = 0; issues = 0; done_cnt = 0; busy_seen = 0;
    exp_q.delete();
    exp_addr = base;
  endtask

  task automatic do_start(input logic [14:0] base, input int len);
    logic [14:0] a;
    clear_score(base);
    for (int i = 0; i < len; i++) begin
      a = base + 15'(i);
      exp_q.push_back({17'b0, a});
    end
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = base; bus.length = 16'(len);
    @(posedge clk); #1;
    bus.start = 1'b0; start_cyc = cyc;
    check("busy_after_start", {31'b0, bus.busy}, {31'b0, len != 0});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
    check({tag, "_done"}, {31'b0, bus.done}, 32'd0);
    check({tag, "_valid"}, {31'b0, bus.src_valid}, 32'd0);
    check({tag, "_cs"}, {31'b0, bus.mem_chipselect}, 32'd0);
    check({tag, "_clken"}, {31'b0, bus.mem_clken}, 32'd0);
    check({tag, "_addr"}, {17'b0, bus.mem_address}, 32'd0);
    check({tag, "_data"}, bus.src_data, 32'd0);
  endtask

  typedef struct {
    logic [14:0] base;
    int          len;
    int          rmode;
    int          ign;
    int          exp_beats;
    int          exp_lat;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  task automatic run_xfer(input vec_t v);
    bit seen_done = 0;
    do_start(v.base, v.len);
    for (int i = 0; i < 400 && !seen_done; i++) begin
      @(posedge clk); #1;
      bus.src_ready = (v.rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v.ign != 0 && i == 1) begin
        bus.start = 1'b1; bus.base_addr = 15'h0200; bus.length = 16'd3;
      end else begin
        bus.start = 1'b0;
      end
      if (done_cnt != 0) seen_done = 1;
    end
    bus.src_ready = 1'b1;
    if (!seen_done) check("done_timeout", 32'd0, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("beats", beats, v.exp_beats);
    check("issues", issues, v.exp_beats);
    check("done_count", done_cnt, 32'd1);
    check("queue_empty", exp_q.size(), 32'd0);
    if (v.exp_beats == 0) begin
      check("len0_done_cyc", done_cyc - start_cyc, 32'd0);
      check("len0_busy", busy_seen, 32'd0);
    end else begin
      check("first_data", first_data, v.exp_first);
      check("last_data", last_data, v.exp_last);
      check("done_after_last", done_cyc - last_cyc, 32'd1);
      if (v.exp_lat >= 0) begin
        check("first_latency", first_cyc - start_cyc, v.exp_lat);
        check("no_bubbles", last_cyc - first_cyc, v.exp_beats - 1);
      end
    end
  endtask

  vec_t vecs[8];

  initial begin
    bit hit;
    vecs[0] = '{15'h0010,  8, 0, 0,  8,  3, 32'h0010, 32'h0017};
    vecs[1] = '{15'h7FFE,  4, 0, 0,  4,  3, 32'h7FFE, 32'h0001};
    vecs[2] = '{15'h0000, 16, 1, 0, 16, -1, 32'h0000, 32'h000F};
    vecs[3] = '{15'h0100,  0, 0, 0,  0, -1, 32'h0000, 32'h0000};
    vecs[4] = '{15'h0020,  1, 0, 0,  1,  3, 32'h0020, 32'h0020};
    vecs[5] = '{15'h0030,  5, 1, 0,  5, -1, 32'h0030, 32'h0034};
    vecs[6] = '{15'h0040,  6, 0, 1,  6,  3, 32'h0040, 32'h0045};
    vecs[7] = '{15'h7FF0, 20, 1, 0, 20, -1, 32'h7FF0, 32'h0003};

    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.src_ready = 1'b1;
    clear_score(15'h0);
    #2;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int k = 0; k < 8; k++) run_xfer(vecs[k]);

    // Reset while the third of ten beats is on the stream
    do_start(15'h0050, 10);
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(posedge clk); #1;
      if (beats >= 2 && bus.src_valid) hit = 1;
    end
    check("beat3_reached", {31'b0, hit}, 32'd1);
    check("beat3_data", bus.src_data, 32'h0052);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    clear_score(15'h0);
    repeat (20) @(posedge clk);
    #1;
    check("post_reset_beats", beats, 32'd0);
    check("post_reset_issues", issues, 32'd0);
    check("post_reset_done", done_cnt, 32'd0);
    check("post_reset_busy", busy_seen, 32'd0);

    run_xfer(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
